// File: rtl/display_pkg.sv
// Shared constants and types for the 7-segment scan path.
// LEADING_ZERO_BLANK_EN (used by display_scan_scheduler) enables leading-zero blanking.
package display_pkg;

    localparam int BCD_W = 4;
    localparam int NDIG  = 4;

    localparam logic [3:0] AN_D3 = 4'h8;
    localparam logic [3:0] AN_D2 = 4'h4;
    localparam logic [3:0] AN_D1 = 4'h2;
    localparam logic [3:0] AN_D0 = 4'h1;

    typedef enum logic [2:0] {
        LATCH = 3'd0,
        SCAN3 = 3'd1,
        SCAN2 = 3'd2,
        SCAN1 = 3'd3,
        SCAN0 = 3'd4
    } state_t;

    function automatic logic [3:0] slot_anode(input logic [1:0] k);
        logic [3:0] an;
        case (k)
            2'd3:    an = AN_D3;
            2'd2:    an = AN_D2;
            2'd1:    an = AN_D1;
            default: an = AN_D0;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-digit dwell counter: tick is high on the last cycle of a DWELL_CYCLES-long slot.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/display_scan_scheduler.sv
// Frame scheduler: snapshots one BCD source per frame and scans it over four anodes.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (rightmost digit always lit).
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_sel,
    input  logic [15:0] ct_bcd,
    input  logic [15:0] f_bcd,
    input  logic        load_req,
    output logic        load_ack,
    output logic        frame_start,
    output logic [3:0]  anode,
    output logic [3:0]  digit_bcd,
    output logic        src_active
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    state_t                  state_reg;
    state_t                  state_next;
    logic [NDIG*BCD_W-1:0]   snapshot_reg;
    logic [NDIG*BCD_W-1:0]   snap_next;
    logic                    pending_reg;
    logic                    take;
    logic                    tick;
    logic                    timer_clear;
    logic                    advance;
    logic [1:0]              enter_k;
    logic [NDIG-1:0]         lead_zero;
    logic                    blank;
    logic [3:0]              anode_reg;
    logic [BCD_W-1:0]        digit_reg;
    logic                    src_active_reg;

    // The snapshot is taken in the LATCH cycle; the slot entered on that same
    // edge must already show the new data, so everything downstream uses snap_next.
    assign take      = (state_reg == LATCH) && (pending_reg || load_req);
    assign snap_next = take ? (src_sel ? ct_bcd : f_bcd) : snapshot_reg;

    // lead_zero[gi]: nibble gi and every more-significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_lead_zero
            assign lead_zero[gi] = (snap_next[NDIG*BCD_W-1 : gi*BCD_W] == '0);
        end
    endgenerate

    always_comb begin
        state_next = LATCH;
        enter_k    = 2'd0;
        advance    = 1'b0;
        case (state_reg)
            LATCH: begin state_next = SCAN3; enter_k = 2'd3; advance = 1'b1; end
            SCAN3: begin state_next = SCAN2; enter_k = 2'd2; advance = tick; end
            SCAN2: begin state_next = SCAN1; enter_k = 2'd1; advance = tick; end
            SCAN1: begin state_next = SCAN0; enter_k = 2'd0; advance = tick; end
            SCAN0: begin state_next = LATCH; enter_k = 2'd0; advance = tick; end
            default: begin state_next = LATCH; advance = 1'b1; end
        endcase
    end

    assign blank       = BLANK_EN && (enter_k != 2'd0) && lead_zero[enter_k];
    assign timer_clear = (state_reg == LATCH) || tick;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(timer_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LATCH;
            snapshot_reg   <= '0;
            pending_reg    <= 1'b1;
            anode_reg      <= 4'h0;
            digit_reg      <= '0;
            src_active_reg <= 1'b0;
        end else begin
            if (take) begin
                snapshot_reg   <= snap_next;
                src_active_reg <= src_sel;
            end
            // A request seen in LATCH is consumed there; only scan-time requests wait.
            if (state_reg == LATCH) begin
                pending_reg <= 1'b0;
            end else if (load_req) begin
                pending_reg <= 1'b1;
            end
            if (advance) begin
                state_reg <= state_next;
                if (state_next == LATCH) begin
                    anode_reg <= 4'h0;
                    digit_reg <= '0;
                end else begin
                    anode_reg <= blank ? 4'h0 : slot_anode(enter_k);
                    digit_reg <= snap_next[{enter_k, 2'b00} +: BCD_W];
                end
            end
        end
    end

    assign anode       = anode_reg;
    assign digit_bcd   = digit_reg;
    assign src_active  = src_active_reg;
    assign frame_start = (state_reg == LATCH) && !rst;
    assign load_ack    = take && !rst;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with DWELL_CYCLES = 4 (17-cycle frames).
module tb_display_scan_scheduler;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        src_sel;
    logic [15:0] ct_bcd;
    logic [15:0] f_bcd;
    logic        load_req;
    logic        load_ack;
    logic        frame_start;
    logic [3:0]  anode;
    logic [3:0]  digit_bcd;
    logic        src_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_scheduler #(
        .DWELL_CYCLES(4),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_sel    (src_sel),
        .ct_bcd     (ct_bcd),
        .f_bcd      (f_bcd),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .frame_start(frame_start),
        .anode      (anode),
        .digit_bcd  (digit_bcd),
        .src_active (src_active)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered while sampling the LATCH cycle; leaves while sampling the next LATCH cycle.
    // act: 1 ct_bcd=0999, 2 req with src_sel=0 f_bcd=1000, 3 req with src_sel=1 ct_bcd=0042,
    //      4 req with ct_bcd=0000. Any raised load_req is dropped one cycle later.
    task automatic run_frame(input string name, input logic [15:0] exp_snap,
                             input logic [3:0] lit, input logic exp_ack,
                             input logic exp_src, input int act_at, input int act);
        int k;
        logic [3:0] exp_an;
        chk({name, " frame_start"}, {15'd0, frame_start}, 16'd1);
        chk({name, " load_ack"}, {15'd0, load_ack}, {15'd0, exp_ack});
        for (int i = 0; i < 16; i++) begin
            step();
            k = 3 - i / 4;
            exp_an = lit[k] ? (4'b0001 << k) : 4'h0;
            chk($sformatf("%s anode c%0d", name, i), {12'd0, anode}, {12'd0, exp_an});
            chk($sformatf("%s digit c%0d", name, i), {12'd0, digit_bcd}, {12'd0, exp_snap[k*4 +: 4]});
            chk($sformatf("%s fs c%0d", name, i), {15'd0, frame_start}, 16'd0);
            chk($sformatf("%s ack c%0d", name, i), {15'd0, load_ack}, 16'd0);
            if (i == 0) chk({name, " src_active"}, {15'd0, src_active}, {15'd0, exp_src});
            if (load_req && i != act_at) load_req = 1'b0;
            if (i == act_at) begin
                case (act)
                    1: ct_bcd = 16'h0999;
                    2: begin src_sel = 1'b0; f_bcd = 16'h1000; load_req = 1'b1; end
                    3: begin src_sel = 1'b1; ct_bcd = 16'h0042; load_req = 1'b1; end
                    4: begin ct_bcd = 16'h0000; load_req = 1'b1; end
                    default: ;
                endcase
            end
        end
        step();
        $display("frame %s snap=%h ack=%0b src=%0b done", name, exp_snap, exp_ack, exp_src);
    endtask

    initial begin
        rst      = 1'b1;
        src_sel  = 1'b1;
        ct_bcd   = 16'h0125;
        f_bcd    = 16'h0000;
        load_req = 1'b0;
        #1;
        chk("rst anode", {12'd0, anode}, 16'd0);
        chk("rst digit", {12'd0, digit_bcd}, 16'd0);
        chk("rst ack", {15'd0, load_ack}, 16'd0);
        chk("rst fs", {15'd0, frame_start}, 16'd0);
        chk("rst src", {15'd0, src_active}, 16'd0);
        step();
        step();
        rst = 1'b0;
        #1;

        run_frame("A", 16'h0125, LZ ? 4'b0111 : 4'b1111, 1'b1, 1'b1, 4, 1);
        run_frame("B", 16'h0125, LZ ? 4'b0111 : 4'b1111, 1'b0, 1'b1, 8, 2);
        run_frame("C", 16'h1000, 4'b1111, 1'b1, 1'b0, 15, 3);
        run_frame("D", 16'h0042, LZ ? 4'b0011 : 4'b1111, 1'b1, 1'b1, -1, 0);
        run_frame("E", 16'h0042, LZ ? 4'b0011 : 4'b1111, 1'b0, 1'b1, 15, 4);
        run_frame("F", 16'h0000, LZ ? 4'b0001 : 4'b1111, 1'b1, 1'b1, -1, 0);

        // Reset in the middle of SCAN2 of frame G; the relaunched frame must reload 0125.
        chk("G ack", {15'd0, load_ack}, 16'd0);
        ct_bcd = 16'h0125;
        for (int i = 0; i < 5; i++) step();
        chk("G pre-rst anode", {12'd0, anode}, LZ ? 16'd0 : 16'h4);
        rst = 1'b1;
        #1;
        chk("midrst anode", {12'd0, anode}, 16'd0);
        chk("midrst digit", {12'd0, digit_bcd}, 16'd0);
        chk("midrst ack", {15'd0, load_ack}, 16'd0);
        chk("midrst src", {15'd0, src_active}, 16'd0);
        step();
        rst = 1'b0;
        #1;
        run_frame("H", 16'h0125, LZ ? 4'b0111 : 4'b1111, 1'b1, 1'b1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
